// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Holds access-size and FSM encodings plus the base byte-lane masks.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ERROR   = 2'd3
    } state_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Encoding 3 is not a legal size; halves and words must be naturally aligned.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the core memory stage and the load/store unit.
// The core side uses the master modport, the LSU the slave modport.
interface dmem_lsu_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lsu_lane_align.sv
// Combinational byte-lane steering: store mask / replicated write data, and
// load byte/half extraction with sign or zero extension.
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_mask,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [31:0] byte_rep;
    logic [31:0] half_rep;
    logic [7:0]  ld_bytes [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_rep[8*gi +: 8] = st_data[7:0];
            assign ld_bytes[gi]        = ld_word[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_rep[16*gi +: 16] = st_data[15:0];
        end
    endgenerate

    assign ld_byte = ld_bytes[lane];
    assign ld_half = lane[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        st_mask = MASK_WORD;
        st_word = st_data;
        ld_data = ld_word;
        case (size)
            SZ_BYTE: begin
                st_mask = MASK_BYTE << lane;
                st_word = byte_rep;
                ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                st_mask = MASK_HALF << lane;
                st_word = half_rep;
                ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            end
            default: begin
                st_mask = MASK_WORD;
                st_word = st_data;
                ld_data = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving port 0 (RW) of the 32x512 data SRAM: one request at a
// time, registered SRAM controls, registered response one cycle after the access.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_lsu_if.slave             bus,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    state_e                state_reg;
    logic [1:0]            size_reg;
    logic [1:0]            lane_reg;
    logic                  uns_reg;
    logic                  we_reg;
    logic                  resp_valid_reg;
    logic                  resp_err_reg;
    logic [31:0]           resp_rdata_reg;
    logic                  csb_reg;
    logic                  web_reg;
    logic [3:0]            wmask_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] din_reg;

    logic                  in_idle;
    logic [1:0]            align_size;
    logic [1:0]            align_lane;
    logic [3:0]            st_mask;
    logic [31:0]           st_word;
    logic [31:0]           ld_data;

    assign in_idle = (state_reg == ST_IDLE);

    // Store steering uses the live request while idle; load extraction uses the latched one.
    assign align_size = in_idle ? bus.req_size     : size_reg;
    assign align_lane = in_idle ? bus.req_addr[1:0] : lane_reg;

    lsu_lane_align u_align (
        .size        (align_size),
        .lane        (align_lane),
        .is_unsigned (uns_reg),
        .st_data     (bus.req_wdata),
        .ld_word     (sram_dout0),
        .st_mask     (st_mask),
        .st_word     (st_word),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            size_reg       <= SZ_BYTE;
            lane_reg       <= 2'b00;
            uns_reg        <= 1'b0;
            we_reg         <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            csb_reg        <= 1'b1;
            web_reg        <= 1'b1;
            wmask_reg      <= '0;
            addr_reg       <= '0;
            din_reg        <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        size_reg <= bus.req_size;
                        lane_reg <= bus.req_addr[1:0];
                        uns_reg  <= bus.req_unsigned;
                        we_reg   <= bus.req_we;
                        if (is_illegal(bus.req_size, bus.req_addr[1:0])) begin
                            state_reg <= ST_ERROR;
                        end else begin
                            state_reg <= ST_ACCESS;
                            csb_reg   <= 1'b0;
                            web_reg   <= ~bus.req_we;
                            addr_reg  <= bus.req_addr[ADDR_WIDTH+1:2];
                            wmask_reg <= bus.req_we ? st_mask : 4'b0000;
                            din_reg   <= bus.req_we ? st_word : '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // The SRAM samples its controls on this edge; release them right away.
                    csb_reg   <= 1'b1;
                    web_reg   <= 1'b1;
                    wmask_reg <= '0;
                    din_reg   <= '0;
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= we_reg ? 32'd0 : ld_data;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= 1'b1;
                    resp_rdata_reg <= '0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = in_idle & ~reset;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.resp_rdata = resp_rdata_reg;

    assign sram_csb0   = csb_reg;
    assign sram_web0   = web_reg;
    assign sram_wmask0 = wmask_reg;
    assign sram_addr0  = addr_reg;
    assign sram_din0   = din_reg;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: table of requests against a behavioural SRAM,
// a response scoreboard, and hand-written reset / back-to-back sequences.
module tb_dmem_lsu;

    localparam int AW = 9;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_mask;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          sram_csb0, sram_web0;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [31:0]   sram_din0;
    logic [31:0]   sram_dout0 = 32'd0;

    dmem_lsu_if #(.ADDR_WIDTH(AW)) bus ();

    dmem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM port 0: samples at the rising edge, acts at the falling edge.
    logic [31:0]   mem [512];
    logic          pend, pend_we;
    logic [AW-1:0] pend_addr;
    logic [3:0]    pend_mask;
    logic [31:0]   pend_din;
    initial begin
        pend = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    end
    always @(posedge clk) begin
        pend      = (sram_csb0 === 1'b0);
        pend_we   = (sram_web0 === 1'b0);
        pend_addr = sram_addr0;
        pend_mask = sram_wmask0;
        pend_din  = sram_din0;
    end
    always @(negedge clk) begin
        if (pend) begin
            if (pend_we) begin
                for (int b = 0; b < 4; b++)
                    if (pend_mask[b]) mem[pend_addr][8*b +: 8] = pend_din[8*b +: 8];
            end else begin
                sram_dout0 = mem[pend_addr];
            end
            pend = 1'b0;
        end
    end

    int   checks   = 0;
    int   failures = 0;
    int   n_resp   = 0;
    exp_t sb [$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none (cyc %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                n_resp++;
                $display("resp %0d cyc=%0d err=%0b rdata=%08h", n_resp, cyc, bus.resp_err, bus.resp_rdata);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, mon_e.err});
                chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
                chk("resp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [10:0] addr, input logic [31:0] wdata,
                                input logic err, input logic [31:0] rdata, input logic [3:0] mask);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_err = err; v.exp_rdata = rdata; v.exp_mask = mask;
        return v;
    endfunction

    function automatic logic [31:0] exp_din(input vec_t v);
        logic [31:0] d;
        case (v.size)
            2'd0:    d = {4{v.wdata[7:0]}};
            2'd1:    d = {2{v.wdata[15:0]}};
            default: d = v.wdata;
        endcase
        return d;
    endfunction

    // Drive a request at a falling edge and wait until it will be accepted at the next rising edge.
    task automatic start_req(input vec_t v, output logic ok);
        int n;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready=%0b expected 1 within 50 cycles", bus.req_ready);
        end
    endtask

    task automatic issue(input vec_t v, output int acc);
        logic ok;
        exp_t e;
        start_req(v, ok);
        acc = cyc + 1;
        if (ok) begin
            e.err   = v.exp_err;
            e.rdata = v.exp_rdata;
            e.cyc   = acc + (v.exp_err ? 1 : 2);
            sb.push_back(e);
            @(negedge clk);
            if (v.exp_err) begin
                chk("err_csb0", {31'd0, sram_csb0}, 32'd1);
            end else begin
                chk("csb0", {31'd0, sram_csb0}, 32'd0);
                chk("web0", {31'd0, sram_web0}, {31'd0, ~v.we});
                chk("addr0", {23'd0, sram_addr0}, {23'd0, v.addr[10:2]});
                if (v.we) begin
                    chk("wmask0", {28'd0, sram_wmask0}, {28'd0, v.exp_mask});
                    chk("din0", sram_din0, exp_din(v));
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_resp_err"},   {31'd0, bus.resp_err}, 32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_csb0"},       {31'd0, sram_csb0}, 32'd1);
        chk({tag, "_web0"},       {31'd0, sram_web0}, 32'd1);
        chk({tag, "_wmask0"},     {28'd0, sram_wmask0}, 32'd0);
        chk({tag, "_addr0"},      {23'd0, sram_addr0}, 32'd0);
        chk({tag, "_din0"},       sram_din0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [$];
    vec_t v;
    int   acc_a, acc_b;
    int   accs [4];
    logic ok;

    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        //       we    size  uns   addr     wdata          err   rdata          mask
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 4'b1111));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 11'h013, 32'h00000080, 1'b0, 32'h00000000, 4'b1000));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 11'h013, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 11'h013, 32'h0,        1'b0, 32'h00000080, 4'b0000));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 11'h020, 32'hAAAA5555, 1'b0, 32'h00000000, 4'b1111));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 11'h022, 32'h00001234, 1'b0, 32'h00000000, 4'b1100));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 11'h020, 32'h0,        1'b0, 32'h12345555, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 11'h022, 32'h0,        1'b0, 32'h00001234, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 11'h012, 32'h0,        1'b0, 32'hFFFF80AD, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 11'h011, 32'h0,        1'b0, 32'h000000BE, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 11'h010, 32'h0,        1'b0, 32'hFFFFFFEF, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd1, 1'b1, 11'h010, 32'h0,        1'b0, 32'h0000BEEF, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd2, 1'b1, 11'h010, 32'h0,        1'b0, 32'h80ADBEEF, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 11'h005, 32'h0,        1'b1, 32'h00000000, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 11'h006, 32'h0,        1'b1, 32'h00000000, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 11'h000, 32'h0,        1'b1, 32'h00000000, 4'b0000));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 11'h002, 32'h77777777, 1'b1, 32'h00000000, 4'b0000));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 11'h7FF, 32'h0000005A, 1'b0, 32'h00000000, 4'b1000));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0,        1'b0, 32'h5A000000, 4'b0000));

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Table-driven single requests
        foreach (vecs[i]) begin
            issue(vecs[i], acc_a);
            bus.req_valid = 1'b0;
        end
        drain();

        // Back-to-back illegal requests: one every 2 cycles
        issue(mk(1'b0, 2'd3, 1'b0, 11'h004, 32'h0, 1'b1, 32'h0, 4'b0), acc_a);
        issue(mk(1'b0, 2'd1, 1'b1, 11'h001, 32'h0, 1'b1, 32'h0, 4'b0), acc_b);
        bus.req_valid = 1'b0;
        chk("err_interval", acc_b - acc_a, 32'd2);
        drain();

        // Reset during ACCESS aborts a store
        issue(mk(1'b1, 2'd2, 1'b0, 11'h030, 32'hCAFEF00D, 1'b0, 32'h0, 4'b1111), acc_a);
        bus.req_valid = 1'b0;
        drain();
        start_req(mk(1'b1, 2'd2, 1'b0, 11'h030, 32'h11111111, 1'b0, 32'h0, 4'b1111), ok);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check_reset_vals("abort");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_post_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_reset_vals("abort_post");
        issue(mk(1'b0, 2'd2, 1'b0, 11'h030, 32'h0, 1'b0, 32'hCAFEF00D, 4'b0), acc_a);
        bus.req_valid = 1'b0;
        drain();

        // Reset during CAPTURE: store still commits, no response
        start_req(mk(1'b1, 2'd2, 1'b0, 11'h040, 32'h0BADCAFE, 1'b0, 32'h0, 4'b1111), ok);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("cap_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        chk("cap_rst_resp_valid_t2", {31'd0, bus.resp_valid}, 32'd0);
        reset = 1'b0;
        issue(mk(1'b0, 2'd2, 1'b0, 11'h040, 32'h0, 1'b0, 32'h0BADCAFE, 4'b0), acc_a);
        bus.req_valid = 1'b0;
        drain();

        // Four back-to-back loads with req_valid held high
        issue(mk(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 1'b0, 32'h80ADBEEF, 4'b0), accs[0]);
        issue(mk(1'b0, 2'd2, 1'b0, 11'h020, 32'h0, 1'b0, 32'h12345555, 4'b0), accs[1]);
        issue(mk(1'b0, 2'd0, 1'b0, 11'h013, 32'h0, 1'b0, 32'hFFFFFF80, 4'b0), accs[2]);
        issue(mk(1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0, 1'b0, 32'h5A000000, 4'b0), accs[3]);
        bus.req_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_interval", accs[i] - accs[i-1], 32'd3);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
